// File: rtl/road_phase_if.sv
// road_phase_if
//   Signal bundle between one road_phase_ctl and its surroundings (cross road,
//   vehicle sensors, lamp driver).
//   slave  : the controller side (sensors/hand-over in, lamp/status out)
//   master : the environment side (drives sensors and hand-over in)
//   Signals:
//     invk_in      hand-over request from the cross road (1-cycle pulse)
//     car_on_own   vehicle present on this road (level)
//     car_on_cross vehicle waiting on the cross road (level)
//     invk_out     hand-over request to the cross road (1-cycle pulse)
//     light        0 = RED, 1 = GREEN, 2 = YELLOW
//     phase_cnt    cycles elapsed in the current state
interface road_phase_if #(
   parameter int CNT_W = 5
);
   logic             invk_in;
   logic             car_on_own;
   logic             car_on_cross;
   logic             invk_out;
   logic [1:0]       light;
   logic [CNT_W-1:0] phase_cnt;

   modport master (
      output invk_in, car_on_own, car_on_cross,
      input  invk_out, light, phase_cnt
   );

   modport slave (
      input  invk_in, car_on_own, car_on_cross,
      output invk_out, light, phase_cnt
   );
endinterface

// File: rtl/road_phase_ctl.sv
// road_phase_ctl
//   Single-road phase controller for a two-road intersection. Cycles
//   RED -> PREP (yellow) -> GREEN -> CLEAR (yellow) -> RED using an internal
//   phase counter. Green lasts at least MIN_GREEN cycles and may be extended
//   while own-road traffic is present, up to MAX_GREEN. Two instances are
//   cross-connected: invk_out of one drives invk_in of the other.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous reset, active-high
//     bus  road_phase_if.slave: invk_in, car_on_own, car_on_cross in;
//          invk_out, light, phase_cnt out
module road_phase_ctl #(
   parameter bit START_GREEN = 1'b1,
   parameter int CNT_W       = 5,
   parameter int SHORT_CYC   = 3,
   parameter int MIN_GREEN   = 8,
   parameter int MAX_GREEN   = 20,
   parameter bit EXT_EN      = 1'b1
) (
   input logic         clk,
   input logic         rst,
   road_phase_if.slave bus
);

   if ((SHORT_CYC < 1) || (MIN_GREEN < 1) || (MIN_GREEN > MAX_GREEN) ||
       (MAX_GREEN >= (2 ** CNT_W))) begin : g_param_check
      $error("road_phase_ctl: illegal SHORT_CYC/MIN_GREEN/MAX_GREEN/CNT_W combination");
   end

   typedef enum logic [1:0] {
      RED   = 2'd0,
      PREP  = 2'd1,
      GREEN = 2'd2,
      CLEAR = 2'd3
   } state_t;

   localparam state_t           RESET_STATE = START_GREEN ? GREEN : RED;
   localparam logic [CNT_W-1:0] SHORT_LAST  = CNT_W'(SHORT_CYC - 1);
   localparam logic [CNT_W-1:0] MIN_LAST    = CNT_W'(MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] MAX_LAST    = CNT_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] CNT_SAT     = '1;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             short_done;
   logic             green_exit;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RESET_STATE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      bus.light  = 2'd2;
      short_done = (cnt == SHORT_LAST);
      // Extension only matters while below the cap; once MAX_LAST is reached
      // the counter keeps climbing, so a late car_on_own cannot re-extend.
      green_exit = (cnt >= MIN_LAST) && bus.car_on_cross &&
                   (!EXT_EN || !bus.car_on_own || (cnt >= MAX_LAST));

      case (state)
         RED: begin
            bus.light = 2'd0;
            if (bus.invk_in) state_nxt = PREP;
         end
         PREP: begin
            if (short_done) state_nxt = GREEN;
         end
         GREEN: begin
            bus.light = 2'd1;
            if (green_exit) state_nxt = CLEAR;
         end
         CLEAR: begin
            if (short_done) state_nxt = RED;
         end
         default: begin
            state_nxt = RESET_STATE;
         end
      endcase

      // Counter restarts on every state entry and saturates while held.
      if (state_nxt != state) begin
         cnt_nxt = '0;
      end else if (cnt != CNT_SAT) begin
         cnt_nxt = cnt + 1'b1;
      end
   end

   assign bus.invk_out  = (state == CLEAR) && short_done;
   assign bus.phase_cnt = cnt;

endmodule

// File: tb/tb_road_phase_ctl.sv
// tb_road_phase_ctl
//   Three controllers: A (START_GREEN=1, EXT_EN=1) and B (START_GREEN=0) can be
//   cross-connected; C (START_GREEN=1, EXT_EN=0) runs standalone with the same
//   car inputs as A. All outputs are compared each cycle to a light/elapsed-time
//   reference model.
module tb_road_phase_ctl;
   localparam int CW   = 5;
   localparam int SC   = 3;
   localparam int MING = 8;
   localparam int MAXG = 20;
   localparam int SAT  = (1 << CW) - 1;

   logic clk;
   logic rst;
   bit   clk_en;
   bit   link;
   logic inv_a, inv_b, inv_c;

   int n_cmp;
   int n_err;

   road_phase_if #(.CNT_W(CW)) ifa ();
   road_phase_if #(.CNT_W(CW)) ifb ();
   road_phase_if #(.CNT_W(CW)) ifc ();

   road_phase_ctl #(.START_GREEN(1'b1), .CNT_W(CW), .SHORT_CYC(SC), .MIN_GREEN(MING),
                    .MAX_GREEN(MAXG), .EXT_EN(1'b1))
      u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   road_phase_ctl #(.START_GREEN(1'b0), .CNT_W(CW), .SHORT_CYC(SC), .MIN_GREEN(MING),
                    .MAX_GREEN(MAXG), .EXT_EN(1'b1))
      u_b (.clk(clk), .rst(rst), .bus(ifb.slave));
   road_phase_ctl #(.START_GREEN(1'b1), .CNT_W(CW), .SHORT_CYC(SC), .MIN_GREEN(MING),
                    .MAX_GREEN(MAXG), .EXT_EN(1'b0))
      u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

   always_comb ifa.invk_in = link ? ifb.invk_out : inv_a;
   always_comb ifb.invk_in = link ? ifa.invk_out : inv_b;
   always_comb ifc.invk_in = inv_c;

   initial begin
      clk = 1'b0;
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   // Reference model: lamp colour, direction of a yellow phase, and unbounded
   // elapsed time in the current lamp phase.
   int m_lt [3];   // 0 red, 1 green, 2 yellow
   bit m_gg [3];   // yellow heading to green
   int m_el [3];
   bit m_sg [3] = '{1'b1, 1'b0, 1'b1};
   bit m_ext[3] = '{1'b1, 1'b1, 1'b0};
   bit in_inv[3], in_own[3], in_crs[3];

   function automatic void m_reset();
      for (int i = 0; i < 3; i++) begin
         m_lt[i] = m_sg[i] ? 1 : 0;
         m_gg[i] = 1'b0;
         m_el[i] = 0;
      end
   endfunction

   function automatic bit m_invk(int i);
      return (m_lt[i] == 2) && !m_gg[i] && (m_el[i] == SC - 1);
   endfunction

   function automatic void m_step();
      for (int i = 0; i < 3; i++) begin
         case (m_lt[i])
            0: begin
               if (in_inv[i]) begin m_lt[i] = 2; m_gg[i] = 1'b1; m_el[i] = 0; end
               else m_el[i]++;
            end
            2: begin
               if (m_el[i] == SC - 1) begin m_lt[i] = m_gg[i] ? 1 : 0; m_el[i] = 0; end
               else m_el[i]++;
            end
            default: begin
               if ((m_el[i] >= MING - 1) && in_crs[i] &&
                   (!m_ext[i] || !in_own[i] || (m_el[i] >= MAXG - 1))) begin
                  m_lt[i] = 2; m_gg[i] = 1'b0; m_el[i] = 0;
               end else m_el[i]++;
            end
         endcase
      end
   endfunction

   task automatic chk(string tag, int act, int exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, act, exp);
      end
   endtask

   task automatic chk_inst(string nm, int i, logic [1:0] lt, logic [CW-1:0] pc, logic iv);
      chk({nm, "_light"}, int'(lt), m_lt[i]);
      chk({nm, "_cnt"}, int'(pc), (m_el[i] > SAT) ? SAT : m_el[i]);
      chk({nm, "_invk"}, int'(iv), int'(m_invk(i)));
   endtask

   task automatic check_all();
      chk_inst("a", 0, ifa.light, ifa.phase_cnt, ifa.invk_out);
      chk_inst("b", 1, ifb.light, ifb.phase_cnt, ifb.invk_out);
      chk_inst("c", 2, ifc.light, ifc.phase_cnt, ifc.invk_out);
      if (link) chk("excl", int'((ifa.light != 2'd0) && (ifb.light != 2'd0)), 0);
   endtask

   // Called at a falling edge: apply inputs, advance the model across the next
   // rising edge, then compare at the following falling edge.
   task automatic cycle(bit ca, bit cb, bit ia, bit ib, bit ic);
      ifa.car_on_own = ca; ifa.car_on_cross = cb;
      ifb.car_on_own = cb; ifb.car_on_cross = ca;
      ifc.car_on_own = ca; ifc.car_on_cross = cb;
      inv_a = ia; inv_b = ib; inv_c = ic;
      in_inv[0] = link ? m_invk(1) : ia;
      in_inv[1] = link ? m_invk(0) : ib;
      in_inv[2] = ic;
      in_own = '{ca, cb, ca};
      in_crs = '{cb, ca, cb};
      m_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      m_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check_all();
   endtask

   initial begin
      bit ca, cb, ok;
      n_cmp = 0; n_err = 0;
      link = 1'b1;
      inv_a = 1'b0; inv_b = 1'b0; inv_c = 1'b0;
      ifa.car_on_own = 1'b0; ifa.car_on_cross = 1'b0;
      ifb.car_on_own = 1'b0; ifb.car_on_cross = 1'b0;
      ifc.car_on_own = 1'b0; ifc.car_on_cross = 1'b0;
      rst = 1'b1;
      clk_en = 1'b1;
      do_reset();

      // Cross traffic only: minimum green, clearance, hand-over.
      repeat (40) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      // Traffic on both roads: extension up to the cap.
      do_reset();
      repeat (70) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      // No cross traffic for a long time: counter saturates, then exit.
      do_reset();
      repeat (45) cycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (10) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Linked random traffic with slowly changing car levels.
      do_reset();
      ca = 1'b0; cb = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) ca = ~ca;
         if ($urandom_range(0, 7) == 0) cb = ~cb;
         cycle(ca, cb, 1'b0, 1'b0, ($urandom_range(0, 5) == 0));
      end

      // Asynchronous reset with the clock stopped, in the last clearance cycle.
      do_reset();
      ok = 1'b0;
      for (int n = 0; n < 200 && !ok; n++) begin
         cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
         ok = m_invk(0);
      end
      chk("reach_clear", int'(ok), 1);
      clk_en = 1'b0;
      #7 rst = 1'b1;
      #1;
      m_reset();
      chk("rst_a_light", int'(ifa.light), 1);
      chk("rst_a_cnt", int'(ifa.phase_cnt), 0);
      chk("rst_a_invk", int'(ifa.invk_out), 0);
      chk("rst_b_invk", int'(ifb.invk_out), 0);
      check_all();
      #4 rst = 1'b0;
      #1 clk_en = 1'b1;
      repeat (30) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

      // Unlinked: random hand-over pulses in every state.
      link = 1'b0;
      do_reset();
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0) ca = ~ca;
         if ($urandom_range(0, 5) == 0) cb = ~cb;
         cycle(ca, cb, ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
